// File: rtl/lcd_bus_writer.sv
// HD44780 byte write engine: latches one {RS, DATA} write, drives setup,
// enable pulse and hold on the LCD bus, then waits out the execution time.
module lcd_bus_writer #(
  parameter int SETUP_CYC     = 4,
  parameter int EN_CYC        = 16,
  parameter int HOLD_CYC      = 4,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int MAX_SE  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAX_HX  = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
  localparam int MAX_A   = (MAX_SE > MAX_HX) ? MAX_SE : MAX_HX;
  localparam int MAX_CYC = (MAX_A > LONG_EXEC_CYC) ? MAX_A : LONG_EXEC_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] LD_LONG  = CW'(LONG_EXEC_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } state_t;

  // Handshake: a write is requested by a 0->1 transition of iStart sampled
  // on iCLK; it is taken only in IDLE (oBusy rises on that edge, oDone
  // drops). Edges seen while busy are dropped. oDone rises together with
  // oBusy falling and stays high until the next accepted request.

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          start_q;
  logic          long_q, long_nxt;
  logic          start;
  logic          en_nxt, done_nxt, busy_nxt, rs_nxt;
  logic [7:0]    data_nxt;
  logic          cnt_zero;

  assign start    = iStart & ~start_q;
  assign cnt_zero = (cnt == '0);
  assign LCD_RW   = 1'b0;

  // State register and registered outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      start_q  <= 1'b0;
      long_q   <= 1'b0;
      LCD_EN   <= 1'b0;
      LCD_DATA <= 8'h00;
      LCD_RS   <= 1'b0;
      oDone    <= 1'b0;
      oBusy    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      start_q  <= iStart;
      long_q   <= long_nxt;
      LCD_EN   <= en_nxt;
      LCD_DATA <= data_nxt;
      LCD_RS   <= rs_nxt;
      oDone    <= done_nxt;
      oBusy    <= busy_nxt;
    end
  end

  // Next state: the shared down-counter is reloaded with N-1 on every entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = LD_EN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = LD_HOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_nxt = ST_EXEC;
          cnt_nxt   = long_q ? LD_LONG : LD_EXEC;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output next values; the bus only changes on an accepted write.
  always_comb begin
    en_nxt   = LCD_EN;
    data_nxt = LCD_DATA;
    rs_nxt   = LCD_RS;
    done_nxt = oDone;
    busy_nxt = oBusy;
    long_nxt = long_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          data_nxt = iDATA;
          rs_nxt   = iRS;
          done_nxt = 1'b0;
          busy_nxt = 1'b1;
          // Clear display / return home need the long execution wait.
          long_nxt = ~iRS && (iDATA == 8'h01 || iDATA == 8'h02 || iDATA == 8'h03);
        end
      end
      ST_SETUP: if (cnt_zero) en_nxt = 1'b1;
      ST_PULSE: if (cnt_zero) en_nxt = 1'b0;
      ST_EXEC: begin
        if (cnt_zero) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end
      end
      default: en_nxt = 1'b0;
    endcase
  end

endmodule

// File: doc/lcd_bus_writer.md
# lcd_bus_writer

Byte-level HD44780 bus write engine that sits directly downstream of the LCD sequencer/animation logic. It accepts one 9-bit write (8-bit data plus RS) via a start/done handshake, drives the character-LCD bus with correct setup, enable-pulse and hold timing, and then waits out the controller execution time. It holds `oDone` high until the next write is accepted.

## Interface
- `SETUP_CYC`, default 4: cycles with RS/DATA valid and `LCD_EN` low before the enable pulse (≥1).
- `EN_CYC`, default 16: `LCD_EN` high width in cycles (≥1).
- `HOLD_CYC`, default 4: cycles with `LCD_EN` low and RS/DATA still held after the pulse (≥1).
- `EXEC_CYC`, default 2000: post-write wait for normal instructions and data, about 40 µs at 50 MHz (≥1).
- `LONG_EXEC_CYC`, default 82000: post-write wait for clear/home instructions, about 1.64 ms at 50 MHz (≥1).
- `iCLK` in 1: sole clock; all logic on its rising edge.
- `iRST` in 1: reset, asynchronous and active-high.
- `iDATA` in 8: byte to write.
- `iRS` in 1: 0 = instruction, 1 = data.
- `iStart` in 1: write request, rising-edge sensitive.
- `oDone` out 1: last write complete; held until the next accepted start.
- `oBusy` out 1: write in progress.
- `LCD_DATA` out 8: LCD data bus.
- `LCD_RW` out 1: constant 0 (write only).
- `LCD_EN` out 1: LCD enable strobe.
- `LCD_RS` out 1: LCD register select.

## Operation
- **Reset values:** all outputs 0 (`LCD_DATA`=0x00, `LCD_RS`=0, `LCD_EN`=0, `LCD_RW`=0, `oDone`=0, `oBusy`=0). State is IDLE, the counter is 0, and the `iStart` history register is 0.
- **Start detect:** a start occurs on a rising edge where `iStart`=1 and the registered previous `iStart`=0.
  - Because the history register resets to 0, `iStart` held high out of reset produces exactly one start.
- **Accepting a start (IDLE only):** latch `iDATA`/`iRS` into `LCD_DATA`/`LCD_RS`, set `oDone`←0 and `oBusy`←1, and enter SETUP.
  - A start edge seen outside IDLE is discarded. It is not queued and does not alter the transfer in progress.
- **Long command select:** latched at accept. A command is long when `iRS`=0 and `iDATA` is 0x01, 0x02 or 0x03; it then uses `LONG_EXEC_CYC`.
  - Every other value uses `EXEC_CYC`, including instruction 0x00 and data 0x01.
- **States:** IDLE → SETUP → PULSE → HOLD → EXEC → IDLE.
  - A single down-counter is loaded with (N−1) on entry to each state. The state advances when the counter reads 0.
- **SETUP:** lasts `SETUP_CYC` cycles with `LCD_EN`=0.
- **PULSE:** lasts `EN_CYC` cycles with `LCD_EN`=1. `LCD_EN` is a registered output.
- **HOLD:** lasts `HOLD_CYC` cycles with `LCD_EN`=0.
- **EXEC:** lasts the selected exec count. On exit, set `oDone`←1 and `oBusy`←0 and return to IDLE.
- **Bus stability:** `LCD_DATA`/`LCD_RS` are stable from accept through the end of EXEC. They keep the last written value in IDLE and never return to 0 except on reset.
- **Counter width:** ceil(log2(max parameter)) bits, 17 at the defaults. No wrap is possible because every count is reloaded per state.
- **Reset mid-transfer:** immediate return to reset values. `LCD_EN` drops asynchronously and no `oDone` is produced.

## Timing
- Let the accepting edge be cycle 0 (`iStart` first sampled high).
- From cycle 0's edge, `oBusy`=1, `oDone`=0 and the bus is valid.
- `LCD_EN` rises at edge `SETUP_CYC` and falls at edge `SETUP_CYC+EN_CYC`.
- `oDone` rises and `oBusy` falls at edge T = `SETUP_CYC+EN_CYC+HOLD_CYC+EXEC` (exec count as selected).
- Earliest next accept: edge T+1, provided `iStart` was seen low at some edge after the last accept.
  - An upstream that holds `iStart` high until `oDone` and then drops it needs ≥2 cycles between writes.
- `oDone` and `oBusy` are never both 1. Between reset and the first start, both are 0.

## Test plan
- **Reset values:** assert `iRST` for 3 cycles, deassert with `iStart`=0 → all outputs 0, `LCD_RW`=0 throughout the test.
- **Data write:** params (2,3,2,5,20); write `iRS`=1, `iDATA`=0x41 → `LCD_DATA`=0x41 and `LCD_RS`=1 from edge 0; `LCD_EN` high on edges 2–4 (3 cycles); `oDone` rises at edge 12; bus still 0x41 afterwards.
- **Long command:** instruction 0x01 → `oDone` at edge 27. Instruction 0x06 → edge 12. Data 0x01 → edge 12.
- **Busy ignore:** start 0x38, then toggle `iStart` low/high at edge 4 with `iDATA`=0x0C → bus stays 0x38, one `oDone` at edge 12, no second transfer; a new edge after `oDone` then writes 0x0C.
- **Reset mid-pulse:** assert `iRST` during PULSE → `LCD_EN`=0 immediately, all outputs 0, and a fresh write then completes normally.
- **Back-to-back writes:** drive 37 consecutive sequencer-style handshakes (`iStart` high until `oDone`, then low for 1 cycle) → 37 enable pulses in order, matching a scoreboard of {RS, DATA}.
